// File: rtl/mode_status_tx_if.sv
// Bus between the mode/time controllers, the UART RX byte stream and the UART TX FIFO
// as seen by the mode status reporter.
interface mode_status_tx_if;
  logic [7:0] pc_data;
  logic       pc_valid;
  logic [1:0] m_sel;
  logic       m_time;
  logic       tx_full;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       busy;

  // master: the reporter itself; slave: the surrounding system (controllers, UART).
  modport master (
    input  pc_data, pc_valid, m_sel, m_time, tx_full,
    output tx_data, tx_push, busy
  );

  modport slave (
    output pc_data, pc_valid, m_sel, m_time, tx_full,
    input  tx_data, tx_push, busy
  );
endinterface

// File: rtl/mode_status_tx.sv
// Sends "M<sel> T<time>\r\n" to the UART TX FIFO on a mode change or on a query byte
// from the PC; the message content is frozen when the message starts.
module mode_status_tx #(
  parameter logic [7:0] QUERY_CHAR  = 8'h3F,
  parameter bit         AUTO_REPORT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  mode_status_tx_if.master bus
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [2:0] LAST_IDX = 3'd6;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [1:0] snap_sel, snap_sel_nxt;
  logic       snap_time, snap_time_nxt;
  logic [1:0] last_sel, last_sel_nxt;
  logic       last_time, last_time_nxt;
  logic       pending, pending_nxt;

  logic       query, change, trigger;
  logic       push;
  logic [7:0] data;

  function automatic logic [7:0] msg_byte(input logic [2:0] i,
                                          input logic [1:0] sel,
                                          input logic       tm);
    logic [7:0] b;
    case (i)
      3'd0:    b = 8'h4D;
      3'd1:    b = 8'h30 + {6'd0, sel};
      3'd2:    b = 8'h20;
      3'd3:    b = 8'h54;
      3'd4:    b = 8'h30 + {7'd0, tm};
      3'd5:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  assign query   = bus.pc_valid && (bus.pc_data == QUERY_CHAR);
  assign change  = AUTO_REPORT && ({bus.m_sel, bus.m_time} != {last_sel, last_time});
  assign trigger = query || change;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      snap_sel  <= 2'b00;
      snap_time <= 1'b0;
      last_sel  <= 2'b00;
      last_time <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      snap_sel  <= snap_sel_nxt;
      snap_time <= snap_time_nxt;
      last_sel  <= last_sel_nxt;
      last_time <= last_time_nxt;
      pending   <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    snap_sel_nxt  = snap_sel;
    snap_time_nxt = snap_time;
    last_sel_nxt  = last_sel;
    last_time_nxt = last_time;
    pending_nxt   = pending;
    push          = 1'b0;
    data          = 8'h00;

    case (state)
      IDLE: begin
        // A trigger collapsed into pending during the previous message starts a new one here.
        if (trigger || pending) begin
          snap_sel_nxt  = bus.m_sel;
          snap_time_nxt = bus.m_time;
          last_sel_nxt  = bus.m_sel;
          last_time_nxt = bus.m_time;
          idx_nxt       = 3'd0;
          pending_nxt   = 1'b0;
          state_nxt     = SEND;
        end
      end
      SEND: begin
        data = msg_byte(idx, snap_sel, snap_time);
        push = !bus.tx_full;
        if (trigger) begin
          pending_nxt = 1'b1;
        end
        if (push) begin
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.tx_push = push;
  assign bus.tx_data = data;
  assign bus.busy    = (state == SEND);

endmodule

// File: tb/tb_mode_status_tx.sv
// Directed bench for mode_status_tx: an expected-byte queue filled from the message
// format, checked by a monitor on every falling edge, plus cycle-exact literal checks.
module tb_mode_status_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mode_status_tx_if bus ();

  mode_status_tx #(
    .QUERY_CHAR (8'h3F),
    .AUTO_REPORT(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int errors   = 0;
  int push_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream of a full report for the given modes.
  task automatic add_msg(input logic [1:0] sel, input logic tm);
    exp_q.push_back(8'h4D);
    exp_q.push_back(8'h30 + {6'd0, sel});
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h30 + {7'd0, tm});
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    chk("push_rule", 32'(bus.tx_push), 32'(bus.busy && !bus.tx_full));
    if (!bus.busy) chk("idle_data", 32'(bus.tx_data), 32'h00);
    if (bus.busy) busy_cnt++;
    if (bus.tx_push) begin
      push_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got %0h expected no push at %0t", bus.tx_data, $time);
      end else begin
        chk("byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int p0, b0;
    rst          = 1'b0;
    bus.pc_data  = 8'h00;
    bus.pc_valid = 1'b0;
    bus.m_sel    = 2'd0;
    bus.m_time   = 1'b0;
    bus.tx_full  = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    // Quiet after reset
    p0 = push_cnt;
    repeat (50) tick();
    chk("reset_no_push", push_cnt - p0, 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_data", 32'(bus.tx_data), 32'h00);

    // Mode change 0 -> 1, free-flowing FIFO
    add_msg(2'd1, 1'b0);
    p0 = push_cnt; b0 = busy_cnt;
    bus.m_sel = 2'd1;
    tick();
    @(negedge clk);
    chk("first_push", 32'(bus.tx_push), 1);
    chk("first_byte", 32'(bus.tx_data), 32'h4D);
    repeat (10) tick();
    chk("chg_pushes", push_cnt - p0, 7);
    chk("chg_busy_cycles", busy_cnt - b0, 7);
    chk("chg_queue_empty", exp_q.size(), 0);

    // Simultaneous change and query: one message only
    add_msg(2'd3, 1'b1);
    p0 = push_cnt;
    bus.m_sel = 2'd3; bus.m_time = 1'b1;
    bus.pc_valid = 1'b1; bus.pc_data = 8'h3F;
    tick();
    bus.pc_valid = 1'b0;
    repeat (10) tick();
    chk("simul_pushes", push_cnt - p0, 7);
    chk("simul_queue_empty", exp_q.size(), 0);

    // Pure query
    add_msg(2'd3, 1'b1);
    p0 = push_cnt;
    bus.pc_valid = 1'b1;
    tick();
    bus.pc_valid = 1'b0;
    repeat (10) tick();
    chk("query_pushes", push_cnt - p0, 7);
    chk("query_queue_empty", exp_q.size(), 0);

    // Query char without valid is ignored
    p0 = push_cnt;
    repeat (10) tick();
    chk("novalid_pushes", push_cnt - p0, 0);
    bus.pc_data = 8'h00;

    // Backpressure on byte 2 for 5 cycles
    add_msg(2'd3, 1'b1);
    p0 = push_cnt;
    bus.pc_valid = 1'b1; bus.pc_data = 8'h3F;
    tick();
    bus.pc_valid = 1'b0;
    repeat (2) tick();
    bus.tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_push", 32'(bus.tx_push), 0);
      chk("stall_data", 32'(bus.tx_data), 32'h20);
      tick();
    end
    bus.tx_full = 1'b0;
    repeat (8) tick();
    chk("bp_pushes", push_cnt - p0, 7);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Snapshot: m_time changes at byte 1, query at byte 4 -> T0 then T1
    add_msg(2'd2, 1'b0);
    add_msg(2'd2, 1'b1);
    p0 = push_cnt;
    bus.m_sel = 2'd2; bus.m_time = 1'b0;
    repeat (2) tick();
    bus.m_time = 1'b1;
    repeat (3) tick();
    bus.pc_valid = 1'b1; bus.pc_data = 8'h3F;
    tick();
    bus.pc_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("gap_push", 32'(bus.tx_push), 0);
    chk("gap_busy", 32'(bus.busy), 0);
    tick();
    @(negedge clk);
    chk("second_push", 32'(bus.tx_push), 1);
    chk("second_byte", 32'(bus.tx_data), 32'h4D);
    repeat (10) tick();
    chk("two_msg_pushes", push_cnt - p0, 14);
    chk("two_msg_queue_empty", exp_q.size(), 0);

    // Reset during byte 3
    exp_q.push_back(8'h4D);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h20);
    bus.m_sel = 2'd0; bus.m_time = 1'b0;
    tick();
    repeat (3) tick();
    chk("b3_push", 32'(bus.tx_push), 1);
    chk("b3_data", 32'(bus.tx_data), 32'h54);
    #2;
    rst = 1'b0;
    #1;
    chk("async_push_drop", 32'(bus.tx_push), 0);
    chk("async_busy_drop", 32'(bus.busy), 0);
    repeat (2) tick();
    rst = 1'b1;
    p0 = push_cnt;
    repeat (30) tick();
    chk("post_reset_pushes", push_cnt - p0, 0);
    chk("post_reset_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_status_tx.md
Name: mode_status_tx

Overview:
- Return path of the PC command link. Reports the current display mode (`m_sel`) and time sub-mode (`m_time`) back to the PC as a short ASCII line.
- Sends a report automatically on every mode change, and on a query byte received from the PC.
- Pushes bytes into the UART TX FIFO through a push/full handshake.
- Sits beside the mode and time controllers, between them and the UART transmitter.

Parameters:
- QUERY_CHAR, 8'h3F ('?'): received byte that forces a report.
- AUTO_REPORT, 1: 1 = report on any change of `m_sel`/`m_time`; 0 = query only.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- pc_data  input  8  byte from UART RX
- pc_valid  input  1  one-cycle strobe; `pc_data` is valid this cycle
- m_sel  input  2  current mode (0 stopwatch, 1 watch, 2 SR, 3 DHT)
- m_time  input  1  time sub-mode (0 sec/msec, 1 hour/min)
- tx_full  input  1  TX FIFO full; no push accepted while high
- tx_data  output  8  byte to push
- tx_push  output  1  push strobe; one byte is written per cycle where it is high
- busy  output  1  high while a message is being sent

Behaviour:
- Message is 7 bytes, in order: 'M'(8'h4D), 8'h30+m_sel, ' '(8'h20), 'T'(8'h54), 8'h30+m_time, 8'h0D, 8'h0A.
- Reset (rst low, asynchronous):
  - state IDLE, byte index 0, `tx_push`=0, `tx_data`=8'h00, `busy`=0, pending=0.
  - Last-reported registers = `m_sel` 2'b00, `m_time` 0. These match the controllers' reset modes, so no report is sent after reset.
- Trigger, sampled each clk:
  - query: `pc_valid`=1 and `pc_data`==QUERY_CHAR; or
  - change: AUTO_REPORT=1 and {`m_sel`,`m_time`} != last-reported.
  - `pc_data` is ignored when `pc_valid`=0.
- State machine, states IDLE and SEND:
  - IDLE + trigger at edge N:
    - snapshot `m_sel`/`m_time` into message registers;
    - update last-reported to the snapshot;
    - index=0, go to SEND; `busy`=1 from N+1.
  - SEND:
    - `tx_data` = message[index], driven from state, index and snapshot.
    - `tx_push` = !`tx_full` (combinational).
    - Index advances only on cycles with `tx_push`=1.
    - After the push of index 6, go to IDLE; `busy` falls the next cycle.
  - IDLE: `tx_push`=0, `tx_data`=8'h00.
- Latency and throughput:
  - First push is in cycle N+1 if `tx_full`=0.
  - With the FIFO never full, all 7 bytes go out in 7 consecutive cycles, N+1..N+7.
- Backpressure:
  - `tx_full`=1 stalls. `tx_data` and index hold, `tx_push`=0.
  - No byte is lost or duplicated. There is no timeout.
- Snapshot consistency:
  - Message content is frozen at message start.
  - Mode changes during SEND do not alter bytes already queued or still pending in the current message.
- Trigger during SEND:
  - Sets pending (a single bit; multiple triggers collapse to one).
  - At return to IDLE with pending=1: clear pending, take a fresh snapshot, start a new message the next cycle.
  - A change that reverts before the message ends still produces a report. A query during SEND produces exactly one extra report.
- Simultaneous query and change in IDLE: one message only.
- Reset mid-message: output stops immediately. The partial message is not resumed. State, pending and last-reported are all reinitialised.
- `m_sel`/`m_time` are synchronous to clk; no synchronisers are needed.

Test Plan:
- Reset, hold rst low, then release with `m_sel`=0, `m_time`=0 and no traffic for 50 cycles -> `tx_push` never asserts, `busy`=0, `tx_data`=8'h00.
- `m_sel` 0->1 with `tx_full`=0 -> 7 consecutive pushes 4D,31,20,54,30,0D,0A starting 1 cycle after the change; `busy` high for exactly 7 cycles.
- `pc_valid` with `pc_data`=8'h3F, `m_sel`=3, `m_time`=1 -> bytes 4D,33,20,54,31,0D,0A. `pc_data`=8'h3F with `pc_valid`=0 -> no output.
- `tx_full` held high for 5 cycles after byte 2 -> `tx_push`=0 for those cycles; `tx_data` holds 8'h20; the remaining bytes follow in order. Total 7 pushes.
- `m_time` toggles 0->1 at byte 1 and a query arrives at byte 4 of a message -> the first message shows T0, then a second message with T1 follows 1 cycle after the first ends. Exactly 2 messages total.
- rst pulsed low during byte 3 -> `tx_push` drops asynchronously. After release with unchanged modes at reset values, no further output.
